// File: rtl/seq_signed_divider.sv
// Sequential signed divider: radix-2 non-restoring core, one quotient bit per clock.
// Optional DIVIDER_BYPASS_EN: divisor==1 / dividend==0 finish in 2 edges instead of WIDTH+2.
module seq_signed_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    CNT_ONE = CW'(1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH:0]   r_dvsr;
    logic             r_neg_q, r_neg_r, r_special, r_dz, r_ovf;
    logic [WIDTH-1:0] r_sq, r_sr;

    logic [WIDTH-1:0] w_abs_dvd, w_abs_dvs;
    logic             w_dz, w_ovf, w_byp;
    logic [WIDTH-1:0] w_sq, w_sr;
    logic [WIDTH:0]   w_shift, w_prem_nx, w_rem_fix;
    logic [WIDTH-1:0] w_q_out, w_r_out;

    // |MIN| is 2^(WIDTH-1), which is still exact as an unsigned WIDTH-bit magnitude
    assign w_abs_dvd = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign w_abs_dvs = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;

    assign w_dz  = (divisor == '0);
    assign w_ovf = (dividend == MIN_VAL) && (divisor == '1);
`ifdef DIVIDER_BYPASS_EN
    assign w_byp = (divisor == WIDTH'(1)) || (dividend == '0);
`else
    assign w_byp = 1'b0;
`endif
    assign w_sq = w_dz ? '1 : (w_ovf ? MIN_VAL : ((divisor == WIDTH'(1)) ? dividend : '0));
    assign w_sr = w_dz ? dividend : '0;

    // Partial remainder sign picks add vs subtract; q bit is set when the result is non-negative
    assign w_shift   = {r_prem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_prem_nx = r_prem[WIDTH] ? (w_shift + r_dvsr) : (w_shift - r_dvsr);
    assign w_rem_fix = r_prem[WIDTH] ? (r_prem + r_dvsr) : r_prem;
    assign w_q_out   = r_neg_q ? ({WIDTH{1'b0}} - r_quo) : r_quo;
    assign w_r_out   = r_neg_r ? ({WIDTH{1'b0}} - w_rem_fix[WIDTH-1:0]) : w_rem_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prem    <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_special <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_sq      <= '0;
            r_sr      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_prem    <= '0;
                        r_quo     <= w_abs_dvd;
                        r_dvsr    <= {1'b0, w_abs_dvs};
                        r_neg_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg_r   <= dividend[WIDTH-1];
                        r_special <= w_dz | w_ovf | w_byp;
                        r_dz      <= w_dz;
                        r_ovf     <= w_ovf;
                        r_sq      <= w_sq;
                        r_sr      <= w_sr;
                        r_cnt     <= CW'(WIDTH - 1);
                        busy      <= 1'b1;
                        div_zero  <= 1'b0;
                        overflow  <= 1'b0;
                        r_state   <= (w_dz | w_ovf | w_byp) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_prem <= w_prem_nx;
                    r_quo  <= {r_quo[WIDTH-2:0], ~w_prem_nx[WIDTH]};
                    r_cnt  <= r_cnt - CNT_ONE;
                    if (r_cnt == '0)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    quotient  <= r_special ? r_sq : w_q_out;
                    remainder <= r_special ? r_sr : w_r_out;
                    div_zero  <= r_dz;
                    overflow  <= r_ovf;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
